// File: rtl/sum_stage_pkg.sv
// Shared sum-stage types: control travelling with multiply-stage beats and row payloads.
// Producer (multiply stage) and consumer (sum_stage) both use these definitions.
package sum_stage_pkg;
  localparam int PEROW   = 4;
  localparam int PSUMDWD = 8;
  localparam int ASUMDWD = 6;
  localparam int PPCTLWD = 6;

  typedef struct packed {
    logic first;
    logic last;
  } SSctl;

  typedef logic [PPCTLWD-1:0] PPctl;

  typedef struct packed {
    logic signed [PSUMDWD-1:0] Psum_MS;
    logic signed [ASUMDWD-1:0] Sum_MS;
  } MSout;

  typedef struct packed {
    SSctl ssctl;
    PPctl ssppctl;
  } MSpipe;

  typedef enum logic {
    SS_ACC  = 1'b0,
    SS_HOLD = 1'b1
  } ss_state_e;
endpackage

// File: rtl/ss_row_acc.sv
// One PE row accumulator: sign-extended add, signed overflow detect, sticky overflow flag.
// Build macro SS_SAT_EN clamps to the signed range on overflow; otherwise the sum wraps.
module ss_row_acc #(
  parameter int PSUMDWD = sum_stage_pkg::PSUMDWD,
  parameter int ASUMDWD = sum_stage_pkg::ASUMDWD
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      en,
  input  logic                      first,
  input  logic signed [PSUMDWD-1:0] psum_in,
  input  logic signed [ASUMDWD-1:0] sum_in,
  output logic signed [PSUMDWD-1:0] acc_next,
  output logic                      ovf_next
);
  localparam int MSB = PSUMDWD - 1;

  logic signed [PSUMDWD-1:0] acc_q;
  logic signed [PSUMDWD-1:0] base;
  logic signed [PSUMDWD-1:0] addend;
  logic signed [PSUMDWD-1:0] wrap;
  logic                      ovf_q;
  logic                      ov;

`ifdef SS_SAT_EN
  localparam logic signed [PSUMDWD-1:0] SMAX = {1'b0, {(PSUMDWD-1){1'b1}}};
  localparam logic signed [PSUMDWD-1:0] SMIN = {1'b1, {(PSUMDWD-1){1'b0}}};
`endif

  always_comb begin
    base   = first ? psum_in : acc_q;
    addend = PSUMDWD'(sum_in);
    wrap   = base + addend;
    // Overflow only when both operands share a sign and the result's sign differs.
    ov     = (base[MSB] == addend[MSB]) && (wrap[MSB] != base[MSB]);
`ifdef SS_SAT_EN
    acc_next = ov ? (base[MSB] ? SMIN : SMAX) : wrap;
`else
    acc_next = wrap;
`endif
    ovf_next = ov || (!first && ovf_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      acc_q <= acc_next;
      ovf_q <= ovf_next;
    end
  end
endmodule

// File: rtl/sum_stage.sv
// Sum stage: accumulates per-row partial sums over first..last beats, holds result for downstream.
// Build macro SS_SAT_EN selects saturating accumulation in every row (default: wrapping).
module sum_stage #(
  parameter int PEROW   = sum_stage_pkg::PEROW,
  parameter int PSUMDWD = sum_stage_pkg::PSUMDWD,
  parameter int ASUMDWD = sum_stage_pkg::ASUMDWD
) (
  input  logic                      i_clk,
  input  logic                      i_rstn,
  input  logic                      MS_rdy,
  output logic                      MS_ack,
  input  sum_stage_pkg::MSout       i_data [PEROW],
  input  sum_stage_pkg::MSpipe      i_MSpipe,
  output logic                      SS_rdy,
  input  logic                      SS_ack,
  output logic signed [PSUMDWD-1:0] o_psum [PEROW],
  output sum_stage_pkg::PPctl       o_ppctl,
  output logic [PEROW-1:0]          o_ovf,
  output sum_stage_pkg::ss_state_e  dbg_state
);
  import sum_stage_pkg::*;

  ss_state_e                 state;
  logic                      beat;
  logic                      last_beat;
  logic signed [PSUMDWD-1:0] acc_next [PEROW];
  logic [PEROW-1:0]          ovf_next;

  // Valid/ready: a beat moves on a port only in a cycle where its rdy and ack are both
  // high. HOLD may drain and refill in the same cycle, so MS_ack looks through to SS_ack.
  assign SS_rdy    = (state == SS_HOLD);
  assign MS_ack    = !SS_rdy || SS_ack;
  assign beat      = MS_rdy && MS_ack;
  assign last_beat = beat && i_MSpipe.ssctl.last;
  assign dbg_state = state;

  for (genvar r = 0; r < PEROW; r++) begin : g_row
    ss_row_acc #(
      .PSUMDWD(PSUMDWD),
      .ASUMDWD(ASUMDWD)
    ) u_row (
      .clk     (i_clk),
      .rstn    (i_rstn),
      .en      (beat),
      .first   (i_MSpipe.ssctl.first),
      .psum_in (i_data[r].Psum_MS),
      .sum_in  (i_data[r].Sum_MS),
      .acc_next(acc_next[r]),
      .ovf_next(ovf_next[r])
    );
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= SS_ACC;
      o_ppctl <= '0;
      o_ovf   <= '0;
      for (int r = 0; r < PEROW; r++) o_psum[r] <= '0;
    end else begin
      if (last_beat) begin
        o_psum  <= acc_next;
        o_ovf   <= ovf_next;
        o_ppctl <= i_MSpipe.ssppctl;
      end
      case (state)
        SS_ACC:  if (last_beat) state <= SS_HOLD;
        SS_HOLD: if (SS_ack && !last_beat) state <= SS_ACC;
        default: state <= SS_ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_sum_stage.sv
// Bench for sum_stage: directed scenarios plus random handshake traffic against an
// arithmetic reference model, results checked through an expected-result queue.
module tb_sum_stage;
  import sum_stage_pkg::*;

  localparam int EW    = PPCTLWD + PEROW + PEROW * PSUMDWD;
  localparam int SMAXI = 2 ** (PSUMDWD - 1) - 1;
  localparam int SMINI = -(2 ** (PSUMDWD - 1));
  localparam int SPAN  = 2 ** PSUMDWD;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic ms_rdy = 1'b0;
  logic ss_ack = 1'b0;
  logic ms_ack;
  logic ss_rdy;
  MSout data [PEROW];
  MSpipe pipe;
  logic signed [PSUMDWD-1:0] psum [PEROW];
  PPctl ppctl;
  logic [PEROW-1:0] ovf;
  ss_state_e state;

  always #5 clk = ~clk;

  sum_stage dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .MS_rdy   (ms_rdy),
    .MS_ack   (ms_ack),
    .i_data   (data),
    .i_MSpipe (pipe),
    .SS_rdy   (ss_rdy),
    .SS_ack   (ss_ack),
    .o_psum   (psum),
    .o_ppctl  (ppctl),
    .o_ovf    (ovf),
    .dbg_state(state)
  );

  // ---------------- reference model and scoreboard ----------------
  int m_acc [PEROW];
  bit m_ovf [PEROW];
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_beats = 0;
  bit acc_flag;

  logic signed [PSUMDWD-1:0] st_psum [PEROW];
  logic signed [ASUMDWD-1:0] st_sum [PEROW];
  PPctl st_pp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic int fold(input int v);
`ifdef SS_SAT_EN
    if (v > SMAXI) return SMAXI;
    if (v < SMINI) return SMINI;
    return v;
`else
    return (((v - SMINI) % SPAN) + SPAN) % SPAN + SMINI;
`endif
  endfunction

  function automatic logic [EW-1:0] pack_out();
    logic [EW-1:0] a;
    a = '0;
    for (int r = 0; r < PEROW; r++) begin
      a[r*PSUMDWD +: PSUMDWD] = psum[r];
      a[PEROW*PSUMDWD + r] = ovf[r];
    end
    a[EW-1 -: PPCTLWD] = ppctl;
    return a;
  endfunction

  task automatic model_accept();
    logic [EW-1:0] e;
    int base;
    int v;
    bit ov;
    e = '0;
    for (int r = 0; r < PEROW; r++) begin
      base = pipe.ssctl.first ? int'(data[r].Psum_MS) : m_acc[r];
      v = base + int'(data[r].Sum_MS);
      ov = (v > SMAXI) || (v < SMINI);
      m_ovf[r] = pipe.ssctl.first ? ov : (m_ovf[r] || ov);
      m_acc[r] = fold(v);
    end
    if (pipe.ssctl.last) begin
      for (int r = 0; r < PEROW; r++) begin
        e[r*PSUMDWD +: PSUMDWD] = PSUMDWD'(m_acc[r]);
        e[PEROW*PSUMDWD + r] = m_ovf[r];
      end
      e[EW-1 -: PPCTLWD] = pipe.ssppctl;
      exp_q.push_back(e);
    end
    n_beats++;
  endtask

  task automatic model_reset();
    for (int r = 0; r < PEROW; r++) begin
      m_acc[r] = 0;
      m_ovf[r] = 1'b0;
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic stage_zero();
    for (int r = 0; r < PEROW; r++) begin
      st_psum[r] = '0;
      st_sum[r] = '0;
    end
    st_pp = '0;
  endtask

  task automatic stage_random();
    for (int r = 0; r < PEROW; r++) begin
      st_psum[r] = PSUMDWD'($urandom_range(0, SPAN - 1));
      st_sum[r] = ASUMDWD'($urandom_range(0, 2 ** ASUMDWD - 1));
    end
    st_pp = PPCTLWD'($urandom_range(0, 2 ** PPCTLWD - 1));
  endtask

  task automatic cycle(input bit v, input bit f, input bit l, input bit ack);
    @(posedge clk);
    #1;
    ms_rdy = v;
    pipe.ssctl.first = f;
    pipe.ssctl.last = l;
    pipe.ssppctl = st_pp;
    ss_ack = ack;
    for (int r = 0; r < PEROW; r++) begin
      data[r].Psum_MS = st_psum[r];
      data[r].Sum_MS = st_sum[r];
    end
    @(negedge clk);
    acc_flag = rstn && ms_rdy && ms_ack;
    if (acc_flag) model_accept();
  endtask

  task automatic send_beat(input bit f, input bit l, input bit ack);
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, f, l, ack);
      if (acc_flag) return;
    end
    check("send_beat_timeout", 64'd0, 64'd1);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [EW-1:0] prev;
    bit hold_prev;
    hold_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) check("hold_stable", {ss_rdy, pack_out()}, {1'b1, prev});
        if (ss_rdy && ss_ack) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: got %0h expected none", pack_out());
          end else begin
            check("result", pack_out(), exp_q.pop_front());
          end
        end
        hold_prev = ss_rdy && !ss_ack;
        prev = pack_out();
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : main
    int target;
    int cyc;
    bit v, f, l, a;
    model_reset();
    stage_zero();
    pipe = '0;
    for (int r = 0; r < PEROW; r++) data[r] = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("reset_ss_rdy", ss_rdy, 1'b0);
    check("reset_ms_ack", ms_ack, 1'b1);
    check("reset_out", pack_out(), '0);
    check("reset_state", state, SS_ACC);

    // Row 0: 10+3, -5, +7 back to back
    stage_zero();
    st_psum[0] = 8'sd10;
    st_sum[0] = 6'sd3;
    send_beat(1'b1, 1'b0, 1'b0);
    st_sum[0] = -6'sd5;
    send_beat(1'b0, 1'b0, 1'b0);
    st_sum[0] = 6'sd7;
    st_pp = 6'h2a;
    send_beat(1'b0, 1'b1, 1'b0);
    check("b2b_beats", n_beats, 3);
    stage_zero();
    st_psum[0] = 8'sd20;
    st_sum[0] = 6'sd5;
    st_pp = 6'h15;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    check("latency_ss_rdy", ss_rdy, 1'b1);
    check("acc_15", $unsigned(psum[0]), 64'd15);

    // Backpressure in HOLD, then drain-and-refill in one cycle
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("hold_ms_ack", ms_ack, 1'b0);
      check("hold_psum", $unsigned(psum[0]), 64'd15);
    end
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    check("refill_accept", acc_flag, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("no_bubble", ss_rdy, 1'b1);
    check("refill_psum", $unsigned(psum[0]), 64'd25);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("drained", ss_rdy, 1'b0);

    // Overflow boundary: 120 + 10 in 8 bits
    stage_zero();
    st_psum[0] = 8'sd120;
    st_sum[0] = 6'sd10;
    send_beat(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SS_SAT_EN
    check("ovf_psum", $unsigned(psum[0]), 64'h7f);
`else
    check("ovf_psum", $unsigned(psum[0]), 64'h82);
`endif
    check("ovf_flag", ovf, 4'b0001);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-accumulation discards the partial result
    stage_zero();
    st_psum[0] = 8'sd5;
    st_sum[0] = 6'sd3;
    send_beat(1'b1, 1'b0, 1'b1);
    send_beat(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    ms_rdy = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_mid_ss_rdy", ss_rdy, 1'b0);
    check("rst_mid_state", state, SS_ACC);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rst_release_ss_rdy", ss_rdy, 1'b0);
    stage_zero();
    st_psum[0] = 8'sd1;
    st_sum[0] = 6'sd1;
    send_beat(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("after_rst_psum", $unsigned(psum[0]), 64'd2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Random valid/ready toggling
    target = n_beats + 1000;
    cyc = 0;
    while (n_beats < target && cyc < 20000) begin
      stage_random();
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 3) == 0);
      a = ($urandom_range(0, 2) != 0);
      cycle(v, f, l, a);
      cyc++;
    end
    check("random_beats", n_beats >= target, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("lost_results", exp_q.size(), 0);
    check("final_ss_rdy", ss_rdy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/sum_stage.md
SUM_STAGE -- requirements
Module: sum_stage

Interface
REQ-001 Parameter PEROW, default PECfg::PEROW, number of PE rows processed in parallel.
REQ-002 Parameter PSUMDWD, default PECfg::PSUMDWD, partial-sum and accumulator width (signed).
REQ-003 Parameter ASUMDWD, default PECtlCfg::ASUMDWD, width of the incoming product sum (signed).
REQ-004 i_clk  input  1  single clock; the block has one clock, all state on rising edge.
REQ-005 i_rstn  input  1  reset, asynchronous, active-low.
REQ-006 MS_rdy  input  1  upstream beat valid.
REQ-007 MS_ack  output  1  sum_stage accepts the upstream beat.
REQ-008 i_data  input  MSout[PEROW]  per-row {Psum_MS, Sum_MS}.
REQ-009 i_MSpipe  input  MSpipe  {ssctl, ssppctl} travelling with the beat.
REQ-010 SS_rdy  output  1  accumulated result valid.
REQ-011 SS_ack  input  1  downstream accepts the result.
REQ-012 o_psum  output  signed PSUMDWD[PEROW]  accumulated partial sums.
REQ-013 o_ppctl  output  PPctl  ssppctl of the beat that closed the accumulation.
REQ-014 o_ovf  output  PEROW  per-row sticky overflow of the current accumulation.

Function
REQ-015 A transfer on either port SHALL occur only in a cycle where rdy and ack are both high; neither data nor control is sampled otherwise.
REQ-016 States SHALL be ACC (collecting beats) and HOLD (result register full, SS_rdy high); reset state is ACC.
REQ-017 MS_ack SHALL be high in ACC, and in HOLD only when SS_ack is high that cycle (drain-and-refill, no bubble).
REQ-018 On an accepted beat, per row: acc <= (ssctl.first ? Psum_MS : acc) + sign-extend(Sum_MS) to PSUMDWD.
REQ-019 Without SS_SAT_EN, the addition SHALL wrap two's-complement; o_ovf[r] SHALL set when signed overflow occurs and clear on a first beat without overflow.
REQ-020 An accepted beat with ssctl.last=1 SHALL load o_psum/o_ppctl and move to HOLD; result visible the cycle after acceptance (latency 1).
REQ-021 HOLD -> ACC on SS_ack when no new beat accepted; HOLD -> HOLD when SS_ack and an accepted last beat coincide.
REQ-022 A beat with first=1 and last=1 SHALL yield Psum_MS + Sum_MS alone.
REQ-023 A non-first beat after a completed result SHALL accumulate onto the last result (no implicit clear); ovf stays sticky until the next first beat.
REQ-024 o_psum, o_ppctl, o_ovf SHALL hold stable while SS_rdy is high and SS_ack low.
REQ-025 Upstream backpressure SHALL never drop or duplicate a beat; MS_rdy falling without ack is legal.

Reset
REQ-026 On i_rstn low, asynchronously: state ACC, acc '0, o_psum '0, o_ppctl '0, o_ovf '0, SS_rdy 0; MS_ack follows state (1) combinationally.
REQ-027 Reset mid-accumulation or in HOLD SHALL discard the partial result with no output beat.

Configuration
REQ-028 Macro SS_SAT_EN: when defined, overflow SHALL clamp acc to the signed PSUMDWD max/min and set o_ovf; when undefined, wrap per REQ-019; o_ovf exists in both builds.

Structure
REQ-029 SSctl {first, last} and PPctl stay in PECtlCfg; MSout and MSpipe move there from the multiply stage so producer and consumer share one definition.
REQ-030 One sub-module ss_row_acc (one per row, generate loop) SHALL hold the add, sign extension, overflow/saturation logic; sum_stage owns FSM and handshake.

Verification
REQ-031 Reset release, MS_rdy=0 -> SS_rdy=0, MS_ack=1, o_psum all 0.
REQ-032 Row0 beats (first,Psum=10,Sum=3),(Sum=-5),(last,Sum=7) back-to-back -> o_psum[0]=15, SS_rdy one cycle after third ack.
REQ-033 Result in HOLD, SS_ack=0 for 5 cycles, MS_rdy=1 -> MS_ack=0, o_psum stable; SS_ack=1 with last beat -> new result next cycle, no bubble.
REQ-034 PSUMDWD=8, Psum=120, Sum=10, first+last -> no SS_SAT_EN: o_psum=-126, o_ovf=1; with SS_SAT_EN: o_psum=127, o_ovf=1.
REQ-035 i_rstn pulsed low after two non-last beats -> no SS_rdy; next (first,last,Psum=1,Sum=1) -> o_psum=2.
REQ-036 Random MS_rdy/SS_ack toggling, 1000 beats -> scoreboard matches reference model, zero lost/duplicated results.
